// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: opcodes, functs, ALU codes,
// datapath mux selects and the multi-cycle controller state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ERROR   = 4'd15
  } state_e;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the controller's ALU operation class and the R-type funct field to an
// ALU control code; funct_legal_o flags functs the ALU does not implement.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_legal_o
);

  logic [2:0] funct_ctrl;

  // NOTE: every output gets a default first so no path through the case
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    funct_ctrl    = ALU_ADD;
    funct_legal_o = 1'b1;
    case (funct_i)
      FUNCT_ADD: funct_ctrl = ALU_ADD;
      FUNCT_SUB: funct_ctrl = ALU_SUB;
      FUNCT_AND: funct_ctrl = ALU_AND;
      FUNCT_OR:  funct_ctrl = ALU_OR;
      FUNCT_SLT: funct_ctrl = ALU_SLT;
      default:   funct_legal_o = 1'b0;
    endcase
  end

  always_comb begin
    case (alu_op_i)
      ALUOP_SUB:   alu_control_o = ALU_SUB;
      ALUOP_FUNCT: alu_control_o = funct_ctrl;
      default:     alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS controller: one state per datapath step, stall-tolerant
// shared memory port, memory watchdog, sticky error state, retire counter.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_BNE  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCEn,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic             RegDest,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             bus_error,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               bus_error_q, bus_error_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  alu_op_e            alu_op;
  logic               funct_legal;
  logic               stalled;
  logic               timeout_hit;

  mips_alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct_i       (Funct),
    .alu_control_o (ALUControl),
    .funct_legal_o (funct_legal)
  );

  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCEn     = 1'b0;
    PCSrc    = PCSRC_ALU;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REGB;
    alu_op   = ALUOP_ADD;
    RegDest  = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
      end
      S_DECODE:  ALUSrcB = SRCB_IMMSH;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDest  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCEn    = (OpCode == OP_BNE) ? ~zero : zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB:  RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = PCSRC_JUMP;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
  end

  assign stalled     = mem_req && !mem_ready;
  assign timeout_hit = (MEM_TIMEOUT > 0) && stalled && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (OpCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_legal ? S_EXECUTE : S_ERROR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE:       state_d = ENABLE_BNE ? S_BRANCH : S_ERROR;
          OP_ADDI:      state_d = ENABLE_ADDI ? S_ADDIEX : S_ERROR;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR:  state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_ERROR;
    endcase
    // mem_ready on the final allowed cycle has already steered state_d away,
    // and timeout_hit is false then, so a late ready still completes.
    if (timeout_hit) state_d = S_ERROR;
  end

  always_comb begin
    if (state_d != state_q)                wait_cnt_d = '0;
    else if ((MEM_TIMEOUT > 0) && stalled) wait_cnt_d = wait_cnt_q + 1'b1;
    else                                   wait_cnt_d = wait_cnt_q;
  end

  // ERROR never leaves except through reset, so any other entry into FETCH
  // is the retirement of the instruction that just finished.
  assign retired_d   = ((state_d == S_FETCH) && (state_q != S_FETCH))
                       ? retired_q + CNT_W'(1) : retired_q;
  assign bus_error_d = bus_error_q || (state_d == S_ERROR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
      retired_q   <= retired_d;
    end
  end

  assign bus_error     = bus_error_q;
  assign state_o       = state_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a watchdog-4 instance for the main
// flows and a bne/addi-disabled instance for illegal-opcode handling.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] OpCode = '0;
  logic [5:0] Funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        a_mem_req, a_iord, a_memwrite, a_irwrite, a_pcen;
  logic [1:0]  a_pcsrc, a_srcb;
  logic        a_srca, a_regdest, a_memtoreg, a_regwrite, a_bus_error;
  logic [2:0]  a_aluctl;
  logic [3:0]  a_state;
  logic [31:0] a_retired;

  logic        b_mem_req, b_iord, b_memwrite, b_irwrite, b_pcen;
  logic [1:0]  b_pcsrc, b_srcb;
  logic        b_srca, b_regdest, b_memtoreg, b_regwrite, b_bus_error;
  logic [2:0]  b_aluctl;
  logic [3:0]  b_state;
  logic [7:0]  b_retired;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4), .ENABLE_ADDI(1'b1), .ENABLE_BNE(1'b1)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(a_mem_req), .IorD(a_iord), .MemWrite(a_memwrite),
    .IRWrite(a_irwrite), .PCEn(a_pcen), .PCSrc(a_pcsrc), .ALUSrcA(a_srca),
    .ALUSrcB(a_srcb), .ALUControl(a_aluctl), .RegDest(a_regdest), .MemtoReg(a_memtoreg),
    .RegWrite(a_regwrite), .bus_error(a_bus_error), .state_o(a_state),
    .instr_retired(a_retired)
  );

  mips_multicycle_ctrl #(.CNT_W(8), .MEM_TIMEOUT(15), .ENABLE_ADDI(1'b0), .ENABLE_BNE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(b_mem_req), .IorD(b_iord), .MemWrite(b_memwrite),
    .IRWrite(b_irwrite), .PCEn(b_pcen), .PCSrc(b_pcsrc), .ALUSrcA(b_srca),
    .ALUSrcB(b_srcb), .ALUControl(b_aluctl), .RegDest(b_regdest), .MemtoReg(b_memtoreg),
    .RegWrite(b_regwrite), .bus_error(b_bus_error), .state_o(b_state),
    .instr_retired(b_retired)
  );

  // Reset is pulsed between edges; both instances end up in FETCH at a negedge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_ret = 0;
  endtask

  task automatic check_fetch_return(input string name);
    #1;
    n_checks++;
    if (a_state !== 4'd0) begin
      n_fail++; $display("FAIL %s_ret_state: got %0d expected 0", name, a_state);
    end
    n_checks++;
    if (a_retired !== 32'(exp_ret)) begin
      n_fail++; $display("FAIL %s_retired: got %0d expected %0d", name, a_retired, exp_ret);
    end
  endtask

  task automatic test_reset();
    mem_ready = 1'b0;
    OpCode = 6'b100011;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (a_state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", a_state); end
    n_checks++;
    if (a_mem_req !== 1'b1 || a_iord !== 1'b0 || a_irwrite !== 1'b0 || a_pcen !== 1'b0) begin
      n_fail++; $display("FAIL reset_fetch_strobes: req=%b iord=%b irw=%b pcen=%b expected 1 0 0 0",
                         a_mem_req, a_iord, a_irwrite, a_pcen);
    end
    n_checks++;
    if (a_srcb !== 2'b01 || a_srca !== 1'b0 || a_aluctl !== 3'b010 || a_pcsrc !== 2'b00) begin
      n_fail++; $display("FAIL reset_fetch_mux: srcb=%b srca=%b alu=%b pcsrc=%b expected 01 0 010 00",
                         a_srcb, a_srca, a_aluctl, a_pcsrc);
    end
    n_checks++;
    if (a_bus_error !== 1'b0 || a_retired !== 32'd0) begin
      n_fail++; $display("FAIL reset_status: bus_error=%b retired=%0d expected 0 0", a_bus_error, a_retired);
    end
    n_checks++;
    if (b_state !== 4'd0 || b_retired !== 8'd0) begin
      n_fail++; $display("FAIL reset_b: state=%0d retired=%0d expected 0 0", b_state, b_retired);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_ret = 0;
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    OpCode = 6'b100011;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (a_state !== exp_s[i]) begin
        n_fail++; $display("FAIL lw_state_c%0d: got %0d expected %0d", i + 1, a_state, exp_s[i]);
      end
      n_checks++;
      if (a_regwrite !== (i == 4) || a_memtoreg !== (i == 4)) begin
        n_fail++; $display("FAIL lw_wb_c%0d: regwrite=%b memtoreg=%b expected %b", i + 1,
                           a_regwrite, a_memtoreg, (i == 4));
      end
      @(negedge clk);
    end
    exp_ret++;
    check_fetch_return("lw");
  endtask

  task automatic branch_case(input logic [5:0] op, input logic z, input logic exp_pcen,
                             input string name);
    logic [3:0] exp_s [3] = '{4'd0, 4'd1, 4'd8};
    OpCode = op;
    zero = z;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (a_state !== exp_s[i]) begin
        n_fail++; $display("FAIL %s_state_c%0d: got %0d expected %0d", name, i + 1, a_state, exp_s[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (a_pcen !== exp_pcen || a_pcsrc !== 2'b01 || a_aluctl !== 3'b110) begin
          n_fail++; $display("FAIL %s_branch: pcen=%b pcsrc=%b alu=%b expected %b 01 110",
                             name, a_pcen, a_pcsrc, a_aluctl, exp_pcen);
        end
      end
      @(negedge clk);
    end
    exp_ret++;
    check_fetch_return(name);
  endtask

  task automatic test_branches();
    branch_case(6'b000100, 1'b1, 1'b1, "beq_taken");
    branch_case(6'b000100, 1'b0, 1'b0, "beq_not_taken");
    branch_case(6'b000101, 1'b1, 1'b0, "bne_not_taken");
    branch_case(6'b000101, 1'b0, 1'b1, "bne_taken");
  endtask

  task automatic test_fetch_stall();
    OpCode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      n_checks++;
      if (a_state !== 4'd0 || a_irwrite !== (i == 3) || a_pcen !== (i == 3)) begin
        n_fail++; $display("FAIL stall_fetch_c%0d: state=%0d irw=%b pcen=%b expected 0 %b %b",
                           i + 1, a_state, a_irwrite, a_pcen, (i == 3), (i == 3));
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (a_state !== 4'd1) begin n_fail++; $display("FAIL stall_decode: got %0d expected 1", a_state); end
    @(negedge clk);
    #1;
    n_checks++;
    if (a_state !== 4'd11 || a_pcen !== 1'b1 || a_pcsrc !== 2'b10) begin
      n_fail++; $display("FAIL jump: state=%0d pcen=%b pcsrc=%b expected 11 1 10", a_state, a_pcen, a_pcsrc);
    end
    @(negedge clk);
    exp_ret++;
    check_fetch_return("jump");
  endtask

  task automatic test_rtype_addi();
    logic [5:0] fn  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ctl [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      OpCode = 6'b000000;
      Funct = fn[k];
      @(negedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (a_state !== 4'd6 || a_aluctl !== ctl[k] || a_srca !== 1'b1 || a_srcb !== 2'b00) begin
        n_fail++; $display("FAIL rtype_exec_f%b: state=%0d alu=%b srca=%b srcb=%b expected 6 %b 1 00",
                           fn[k], a_state, a_aluctl, a_srca, a_srcb, ctl[k]);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (a_state !== 4'd7 || a_regwrite !== 1'b1 || a_regdest !== 1'b1 || a_memtoreg !== 1'b0) begin
        n_fail++; $display("FAIL rtype_wb_f%b: state=%0d regw=%b regdst=%b m2r=%b expected 7 1 1 0",
                           fn[k], a_state, a_regwrite, a_regdest, a_memtoreg);
      end
      @(negedge clk);
      exp_ret++;
      check_fetch_return("rtype");
    end
    OpCode = 6'b001000;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (a_state !== 4'd9 || a_srca !== 1'b1 || a_srcb !== 2'b10 || a_aluctl !== 3'b010) begin
      n_fail++; $display("FAIL addi_ex: state=%0d srca=%b srcb=%b alu=%b expected 9 1 10 010",
                         a_state, a_srca, a_srcb, a_aluctl);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (a_state !== 4'd10 || a_regwrite !== 1'b1 || a_regdest !== 1'b0) begin
      n_fail++; $display("FAIL addi_wb: state=%0d regw=%b regdst=%b expected 10 1 0",
                         a_state, a_regwrite, a_regdest);
    end
    @(negedge clk);
    exp_ret++;
    check_fetch_return("addi");
  endtask

  task automatic test_async_reset();
    OpCode = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (a_state !== 4'd5 || a_memwrite !== 1'b1 || a_retired !== 32'(exp_ret)) begin
      n_fail++; $display("FAIL areset_pre: state=%0d memwrite=%b retired=%0d expected 5 1 %0d",
                         a_state, a_memwrite, a_retired, exp_ret);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (a_memwrite !== 1'b0 || a_state !== 4'd0 || a_retired !== 32'd0 || a_mem_req !== 1'b1) begin
      n_fail++; $display("FAIL areset_mid_memwr: memwrite=%b state=%0d retired=%0d req=%b expected 0 0 0 1",
                         a_memwrite, a_state, a_retired, a_mem_req);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_ret = 0;
  endtask

  task automatic test_timeout(input bit late_ready, input string name);
    OpCode = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mem_ready = late_ready && (i == 3);
      #1;
      n_checks++;
      if (a_state !== 4'd5 || a_memwrite !== 1'b1 || a_mem_req !== 1'b1) begin
        n_fail++; $display("FAIL %s_wait_c%0d: state=%0d memwrite=%b req=%b expected 5 1 1",
                           name, i + 1, a_state, a_memwrite, a_mem_req);
      end
      @(negedge clk);
    end
    #1;
    if (late_ready) begin
      exp_ret++;
      n_checks++;
      if (a_state !== 4'd0 || a_bus_error !== 1'b0 || a_retired !== 32'(exp_ret)) begin
        n_fail++; $display("FAIL %s_complete: state=%0d bus_error=%b retired=%0d expected 0 0 %0d",
                           name, a_state, a_bus_error, a_retired, exp_ret);
      end
    end else begin
      n_checks++;
      if (a_state !== 4'd15 || a_bus_error !== 1'b1 || a_mem_req !== 1'b0 || a_memwrite !== 1'b0) begin
        n_fail++; $display("FAIL %s_error: state=%0d bus_error=%b req=%b memwrite=%b expected 15 1 0 0",
                           name, a_state, a_bus_error, a_mem_req, a_memwrite);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (a_state !== 4'd15 || a_bus_error !== 1'b1 || a_retired !== 32'(exp_ret)) begin
        n_fail++; $display("FAIL %s_sticky: state=%0d bus_error=%b retired=%0d expected 15 1 %0d",
                           name, a_state, a_bus_error, a_retired, exp_ret);
      end
      do_reset();
      #1;
      n_checks++;
      if (a_state !== 4'd0 || a_bus_error !== 1'b0 || a_retired !== 32'd0) begin
        n_fail++; $display("FAIL %s_cleared: state=%0d bus_error=%b retired=%0d expected 0 0 0",
                           name, a_state, a_bus_error, a_retired);
      end
    end
  endtask

  task automatic illegal_case(input logic [5:0] op, input logic [5:0] fn, input bit on_b,
                              input string name);
    logic [3:0] exp_s [3] = '{4'd0, 4'd1, 4'd15};
    logic [3:0] st;
    logic       rw, be;
    do_reset();
    OpCode = op;
    Funct = fn;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      st = on_b ? b_state : a_state;
      rw = on_b ? b_regwrite : a_regwrite;
      be = on_b ? b_bus_error : a_bus_error;
      n_checks++;
      if (st !== exp_s[i] || rw !== 1'b0 || be !== (i == 2)) begin
        n_fail++; $display("FAIL %s_c%0d: state=%0d regwrite=%b bus_error=%b expected %0d 0 %b",
                           name, i + 1, st, rw, be, exp_s[i], (i == 2));
      end
      @(negedge clk);
    end
    #1;
    st = on_b ? b_state : a_state;
    rw = on_b ? b_regwrite : a_regwrite;
    n_checks++;
    if (st !== 4'd15 || rw !== 1'b0) begin
      n_fail++; $display("FAIL %s_hold: state=%0d regwrite=%b expected 15 0", name, st, rw);
    end
  endtask

  task automatic test_illegal();
    illegal_case(6'b111111, 6'b100000, 1'b0, "illegal_op");
    illegal_case(6'b000101, 6'b100000, 1'b1, "bne_disabled");
    illegal_case(6'b000000, 6'b000000, 1'b0, "illegal_funct");
    illegal_case(6'b001000, 6'b100000, 1'b1, "addi_disabled");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_branches();
    test_fetch_stall();
    test_rtype_addi();
    test_async_reset();
    test_timeout(1'b0, "timeout");
    test_timeout(1'b1, "late_ready");
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in 200000 time units");
    $fatal(1, "bench time limit expired");
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Control FSM for the multi-cycle generation of the MIPS core. It replaces the single-cycle combinational decode with a state-per-step controller.
- Instruction and data memory are a single shared port with a request/ready handshake, so any memory access may stall.
- Adds a configurable memory-timeout watchdog, a sticky error state and a retired-instruction counter.
- Sits between the instruction register and the multi-cycle datapath, and drives all datapath enables and mux selects.

Parameters:
CNT_W, 32, width of the instr_retired counter (wraps modulo 2^CNT_W)
MEM_TIMEOUT, 15, consecutive un-ready wait cycles before bus error; 0 disables the watchdog
ENABLE_ADDI, 1, 1 = opcode 001000 legal; 0 = illegal
ENABLE_BNE, 1, 1 = opcode 000101 legal; 0 = illegal

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
OpCode  in  6  instr[31:26] from instruction register
Funct  in  6  instr[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current request this cycle
mem_req  out  1  memory access request
IorD  out  1  0 = PC address, 1 = ALUOut address
MemWrite  out  1  write strobe, valid while mem_req
IRWrite  out  1  load instruction register
PCEn  out  1  PC register enable
PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
RegDest  out  1  1 = rd, 0 = rt
MemtoReg  out  1  1 = memory data, 0 = ALUOut
RegWrite  out  1  register file write enable
bus_error  out  1  sticky: watchdog expiry or illegal instruction
state_o  out  4  current state encoding (debug)
instr_retired  out  CNT_W  completed-instruction count

Behaviour:
- Reset (asynchronous, any cycle, including mid-access):
  - state = FETCH, wait_cnt = 0, bus_error = 0, instr_retired = 0.
  - All outputs take their FETCH values immediately.
- State encodings (4 bits): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, ERROR 15.
- Per-state outputs. Any output not listed is 0, and ALUControl defaults to 010.
  - FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00; IRWrite=PCEn=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, add.
    - Next state by OpCode: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 / 000101 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
    - Any other opcode, a disabled opcode, or an R-type Funct not in {100000, 100010, 100100, 100101, 101010} -> ERROR.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, add. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req=1, IorD=1. Stay until mem_ready, then go to MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDest=0. Go to FETCH.
  - MEMWR: mem_req=1, IorD=1, MemWrite=1, held through the wait. Go to FETCH on mem_ready.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl by Funct: add 010, sub 110, and 000, or 001, slt 111. Go to ALUWB.
  - ALUWB: RegWrite=1, RegDest=1. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01. PCEn = zero for beq, ~zero for bne. Go to FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Go to ADDIWB.
  - ADDIWB: RegWrite=1, RegDest=0. Go to FETCH.
  - JUMP: PCSrc=10, PCEn=1. Go to FETCH.
  - ERROR: bus_error=1, all strobes 0, mem_req=0. The only exit is reset.
- Watchdog (applies only when MEM_TIMEOUT > 0):
  - wait_cnt increments each cycle with mem_req=1 and mem_ready=0, and clears on any state change.
  - On the MEM_TIMEOUT-th consecutive un-ready cycle the next state is ERROR.
  - If mem_ready arrives on that same cycle, it wins and the access completes normally.
  - wait_cnt width = clog2(MEM_TIMEOUT+1).
- instr_retired increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. Reset-entry does not count.
- Latency with zero-wait memory:
  - lw 5 cycles; sw, R-type, addi 4; beq/bne/j 3.
  - Each un-ready cycle adds 1.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct localparams;
  - ALUControl codes;
  - the state encoding enum;
  - PCSrc and ALUSrcB select codes.
- One sub-module is natural: mips_alu_decoder. It is combinational and maps (ALUOp, Funct) to ALUControl plus a funct_legal flag, and is reused from the single-cycle control path.

Test Plan:
- Reset, lw (100011), mem_ready=1 throughout -> states 0,1,2,3,4; MemtoReg=RegWrite=1 only in cycle 5; instr_retired=1.
- beq with zero=1 -> PCEn=1 in BRANCH; beq with zero=0 -> PCEn=0. bne inverts both cases. Each takes 3 cycles.
- FETCH with mem_ready low 3 cycles then high -> 4 cycles in FETCH; IRWrite and PCEn pulse exactly once, on cycle 4.
- MEM_TIMEOUT=4, sw with mem_ready stuck low -> MemWrite held for 4 cycles, then ERROR with bus_error=1, mem_req=0; reset clears. Repeat with mem_ready rising on the 4th cycle -> normal completion.
- OpCode 111111; ENABLE_BNE=0 with 000101; R-type Funct 000000 -> each goes DECODE->ERROR, RegWrite never asserted.
- Async reset asserted mid-MEMWR (between edges) -> MemWrite falls immediately, state_o=0, instr_retired=0.
